// File: rtl/ram16k_arbiter.sv
// Round-robin arbiter sharing one RAM16K between a CPU port (A) and a screen/DMA port (B),
// plus a sequencer that zeroes every word on command.
module ram16k_arbiter #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_load,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_load,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  input  logic          clear_start,
  output logic          clear_busy,
  output logic          mem_load,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_in,
  input  logic [DW-1:0] mem_out
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic          r_last, w_last_nxt;   // 1 = B was granted most recently
  logic          r_a_rv, r_b_rv;
  logic          w_a_gnt, w_b_gnt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_a_gnt     = 1'b0;
    w_b_gnt     = 1'b0;
    mem_load    = 1'b0;
    mem_address = '0;
    mem_in      = '0;
    case (r_state)
      S_IDLE: begin
        w_a_gnt = a_req && (!b_req || r_last);
        w_b_gnt = b_req && !w_a_gnt;
        if (w_a_gnt) begin
          mem_load    = a_load;
          mem_address = a_addr;
          mem_in      = a_wdata;
          w_last_nxt  = 1'b0;
        end else if (w_b_gnt) begin
          mem_load    = b_load;
          mem_address = b_addr;
          mem_in      = b_wdata;
          w_last_nxt  = 1'b1;
        end
        if (clear_start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        mem_load    = 1'b1;
        mem_address = r_cnt;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Reset cycles present a quiet bus regardless of the registered state.
    if (reset) begin
      w_a_gnt     = 1'b0;
      w_b_gnt     = 1'b0;
      mem_load    = 1'b0;
      mem_address = '0;
      mem_in      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_a_rv  <= 1'b0;
      r_b_rv  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_a_rv  <= w_a_gnt && !a_load;
      r_b_rv  <= w_b_gnt && !b_load;
    end
  end

  assign a_gnt      = w_a_gnt;
  assign b_gnt      = w_b_gnt;
  assign a_rvalid   = r_a_rv && !reset;
  assign b_rvalid   = r_b_rv && !reset;
  assign a_rdata    = mem_out;
  assign b_rdata    = mem_out;
  assign clear_busy = (r_state == S_CLEAR) && !reset;

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Scoreboard bench: a cycle-level reference model predicts grants, bus values and read data;
// a separate monitor matches every rvalid against the queued expectations.
module tb_ram16k_arbiter;
  localparam int DEPTH = 16384;
  localparam int AW = 14;
  localparam int DW = 16;

  logic clk = 0;
  logic reset, clear_start, clear_busy;
  logic a_req, a_load, a_gnt, a_rvalid, b_req, b_load, b_gnt, b_rvalid;
  logic [AW-1:0] a_addr, b_addr, mem_address;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_in, mem_out;
  logic mem_load;

  always #5 clk = ~clk;

  ram16k_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_load(a_load), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_load(b_load), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .mem_load(mem_load), .mem_address(mem_address), .mem_in(mem_in), .mem_out(mem_out)
  );

  // RAM16K with registered output
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_load) ram[mem_address] <= mem_in;
    mem_out <= ram[mem_address];
  end

  typedef struct { int unsigned cyc; logic [DW-1:0] d; } exp_t;
  exp_t aq[$];
  exp_t bq[$];

  logic [DW-1:0] ref_mem [DEPTH];
  int  m_busy;       // clear cycles still to run
  bit  m_last;       // 1 = B granted most recently
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (aq.size() > 0 && aq[0].cyc < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL a_rvalid_missing cyc=%0d got=0 exp=1 (due %0d)", cyc, aq[0].cyc);
      void'(aq.pop_front());
    end
    if (a_rvalid) begin
      if (aq.size() == 0) chk("a_rvalid_spurious", 1, 0);
      else begin
        e = aq.pop_front();
        chk("a_rvalid_cycle", cyc, e.cyc);
        chk("a_rdata", a_rdata, e.d);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bq.size() > 0 && bq[0].cyc < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL b_rvalid_missing cyc=%0d got=0 exp=1 (due %0d)", cyc, bq[0].cyc);
      void'(bq.pop_front());
    end
    if (b_rvalid) begin
      if (bq.size() == 0) chk("b_rvalid_spurious", 1, 0);
      else begin
        e = bq.pop_front();
        chk("b_rvalid_cycle", cyc, e.cyc);
        chk("b_rdata", b_rdata, e.d);
      end
    end
  end

  // One clock cycle: predict, compare at negedge, advance the model, then drop served requests.
  task automatic tick();
    logic ea, eb, el, ebusy;
    logic [AW-1:0] ead;
    logic [DW-1:0] ein;
    ea = 0; eb = 0; el = 0; ebusy = 0; ead = '0; ein = '0;
    if (reset) begin
      m_busy = 0; m_last = 1;
      aq.delete(); bq.delete();
    end else if (m_busy > 0) begin
      ebusy = 1; el = 1; ead = AW'(DEPTH - m_busy);
    end else begin
      ea = a_req && (!b_req || m_last);
      eb = b_req && !ea;
      if (ea) begin el = a_load; ead = a_addr; ein = a_wdata; end
      else if (eb) begin el = b_load; ead = b_addr; ein = b_wdata; end
    end
    @(negedge clk);
    chk("a_gnt", a_gnt, ea);
    chk("b_gnt", b_gnt, eb);
    chk("clear_busy", clear_busy, ebusy);
    chk("mem_load", mem_load, el);
    chk("mem_address", mem_address, ead);
    chk("mem_in", mem_in, ein);
    if (!reset) begin
      if (ebusy) begin
        ref_mem[ead] = '0;
        m_busy--;
      end else begin
        if (ea) begin
          if (a_load) ref_mem[a_addr] = a_wdata;
          else aq.push_back('{cyc + 1, ref_mem[a_addr]});
          m_last = 0;
        end
        if (eb) begin
          if (b_load) ref_mem[b_addr] = b_wdata;
          else bq.push_back('{cyc + 1, ref_mem[b_addr]});
          m_last = 1;
        end
        if (clear_start) m_busy = DEPTH;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (ea) a_req = 0;
    if (eb) b_req = 0;
    clear_start = 0;
    reset = 0;
  endtask

  task automatic areq(input logic ld, input int ad, input logic [DW-1:0] wd);
    a_req = 1; a_load = ld; a_addr = AW'(ad); a_wdata = wd;
  endtask

  task automatic breq(input logic ld, input int ad, input logic [DW-1:0] wd);
    b_req = 1; b_load = ld; b_addr = AW'(ad); b_wdata = wd;
  endtask

  function automatic int pick_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 8) return 8191;
    if (r == 9) return DEPTH - 1;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    reset = 1; clear_start = 0;
    a_req = 0; a_load = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_load = 0; b_addr = '0; b_wdata = '0;
    m_busy = 0; m_last = 1;
    @(posedge clk); #1;
    reset = 1;
    tick();

    // A write then read of address 5
    areq(1, 5, 16'h1234); tick();
    areq(0, 5, 0); tick();
    tick();

    // Preload, then both read continuously: grants alternate starting with A
    areq(1, 1, 16'h00AA); tick();
    breq(1, 2, 16'h00BB); tick();
    repeat (8) begin
      if (!a_req) areq(0, 1, 0);
      if (!b_req) breq(0, 2, 0);
      tick();
    end
    b_req = 0; a_req = 0; tick(); tick();

    // B alone: back-to-back writes then readback
    for (int i = 0; i < 8; i++) begin breq(1, i, DW'($urandom)); tick(); end
    for (int i = 0; i < 8; i++) begin breq(0, i, 0); tick(); end
    tick();

    // Full clear with a request held through it and a stray clear_start mid-sweep
    areq(1, 0, 16'hFFFF); tick();
    areq(1, 8191, 16'hFFFF); tick();
    areq(1, DEPTH - 1, 16'hFFFF); tick();
    clear_start = 1; tick();
    areq(0, 8191, 0);
    for (int k = 0; m_busy > 0 && k < DEPTH + 10; k++) begin
      if (k == 50) clear_start = 1;
      tick();
    end
    tick();
    breq(0, 0, 0); tick();
    breq(0, DEPTH - 1, 0); tick();
    tick();

    // Reset in the middle of a sweep, then a complete sweep from address 0
    areq(1, 3, 16'hBEEF); tick();
    clear_start = 1; tick();
    repeat (100) tick();
    reset = 1; tick();
    tick();
    areq(0, 3, 0); tick();
    areq(1, 20, 16'h5A5A); tick();
    clear_start = 1; tick();
    for (int k = 0; m_busy > 0 && k < DEPTH + 10; k++) tick();
    areq(0, 20, 0); breq(0, 3, 0); tick(); tick(); tick();

    // Random traffic on both ports
    repeat (500) begin
      if (!a_req && $urandom_range(0, 2) != 0) areq(1'($urandom), pick_addr(), DW'($urandom));
      if (!b_req && $urandom_range(0, 2) != 0) breq(1'($urandom), pick_addr(), DW'($urandom));
      tick();
    end
    a_req = 0; b_req = 0;
    tick(); tick();
    chk("a_queue_drained", aq.size(), 0);
    chk("b_queue_drained", bq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram16k_arbiter.md
# ram16k_arbiter

Two-requester access controller for the 16K x 16 data memory. It shares one RAM16K between requester A (CPU data port) and requester B (screen/DMA port) using round-robin arbitration, one access per cycle. It also provides a memory-clear sequencer that zeroes all 16384 words on command. The block sits between the requesters and the RAM16K instance: it drives the RAM's load, address and in pins and consumes the RAM's out.

## Interface

Parameters:
- DEPTH, 16384: words in the attached RAM; the clear sequencer sweeps addresses 0..DEPTH-1.
- AW, 14: address width.
- DW, 16: data width.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  requester A access request.
- a_load  in  1  A: 1 = write, 0 = read.
- a_addr  in  AW  A address.
- a_wdata  in  DW  A write data.
- a_gnt  out  1  A access accepted this cycle.
- a_rvalid  out  1  A read data valid.
- a_rdata  out  DW  A read data.
- b_req, b_load, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for requester B.
- clear_start  in  1  one-cycle request to zero the whole memory.
- clear_busy  out  1  clear sweep in progress.
- mem_load  out  1  to RAM load.
- mem_address  out  AW  to RAM address.
- mem_in  out  DW  to RAM in.
- mem_out  in  DW  from RAM out; registered, valid the cycle after the address is presented.

## Operation

- FSM states are IDLE and CLEAR. Reset state is IDLE with clear counter 0 and round-robin pointer `last` = B, so A wins the first tie.
- IDLE arbitration is combinational within the cycle:
  - Only one requester asserts req: it is granted.
  - Both assert req: the one not granted most recently is granted. `last` updates on every grant.
  - The granted requester's load/addr/wdata drive mem_load/mem_address/mem_in, and its gnt is 1.
- No grant in a cycle: mem_load=0, mem_address=0, mem_in=0.
- Requester rule: hold req, load, addr and wdata stable until gnt is seen. The next request may start the cycle after gnt. gnt never asserts without req.
- Granted read: that requester's rvalid=1 in the following cycle, with rdata = mem_out. A granted write produces no rvalid.
- a_rdata and b_rdata are wired to mem_out continuously and are meaningful only while the matching rvalid is high.
- A single active requester is granted every cycle, at full throughput.
- clear_start sampled high in IDLE (reset low):
  - The current cycle still arbitrates normally.
  - The next cycle enters CLEAR.
- CLEAR:
  - Every cycle drives mem_load=1, mem_in=0 and mem_address = counter, then increments the counter.
  - No gnt is issued. Requests wait.
  - After the write to address DEPTH-1, the FSM returns to IDLE and the counter returns to 0.
- clear_start while in CLEAR is ignored.
- A read granted in the cycle before CLEAR still returns rvalid in the first CLEAR cycle.

## Timing

- Reset values, and values during any reset cycle: a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, clear_busy=0, mem_load=0, mem_address=0, mem_in=0.
- Reset forces IDLE from any state. A clear in progress is aborted mid-sweep, with the counter cleared to 0 and pending rvalid dropped.
- Read latency: request granted in cycle T, data in cycle T+1 (rvalid high for exactly one cycle).
- Write: the RAM is updated at the posedge ending cycle T. A read of the same address granted in T+1 returns the new data in T+2.
- Clear duration: clear_busy is high for exactly DEPTH consecutive cycles, T+1 .. T+DEPTH, where clear_start is sampled in T. Arbitration resumes in cycle T+DEPTH+1.
- clear_busy is registered, equal to (state == CLEAR).
- Simultaneous clear_start and requests in IDLE: the requests are arbitrated in that cycle, and clear takes effect the next cycle.

## Test plan

- Reset, then A writes 0x1234 to addr 5 and A reads addr 5 -> a_gnt immediately on each request; the cycle after the read grant, a_rvalid=1 and a_rdata=0x1234.
- Both requesters read continuously (A addr 1, B addr 2, preloaded 0x00AA and 0x00BB) -> grants alternate A,B,A,B starting with A; each rvalid is one cycle after its grant with the correct data.
- B alone requests back-to-back writes to addrs 0..7 -> b_gnt high 8 consecutive cycles; readback is correct.
- Write 0xFFFF to addrs 0, 8191 and 16383, then pulse clear_start -> clear_busy high exactly 16384 cycles with no grants during the sweep; subsequent reads of all three addresses return 0x0000.
- A request held during clear -> a_gnt in the first cycle after clear_busy falls. A clear_start pulse during the sweep does not extend it.
- Assert reset at cycle 100 of a clear -> next cycle clear_busy=0 and all outputs at reset values. A new clear_start after reset runs the full 16384 cycles from addr 0.
